// File: rtl/riscv_banked_register_file.sv
// Flip-flop register file for RI5CY/XCrypto: integer GPRs (x0 = 0), optional FP and XC banks,
// three read ports, two write ports, optional write bypass and a sequenced XC-bank clear.
module riscv_banked_register_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int FPU           = 0,
    parameter int XPU           = 1,
    parameter int NUM_XC        = 16,
    parameter int CLR_PER_CYCLE = 1,
    parameter int WRITE_BYPASS  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fregfile_disable_i,
    input  logic [6:0]            raddr_a_i,
    input  logic [6:0]            raddr_b_i,
    input  logic [6:0]            raddr_c_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    output logic [DATA_WIDTH-1:0] rdata_c_o,
    input  logic [6:0]            waddr_a_i,
    input  logic [6:0]            waddr_b_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_b_i,
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic                  xc_init_req_i,
    output logic                  xc_init_busy_o,
    output logic                  xc_init_done_o
);

    localparam int XC_AW = (NUM_XC > 1) ? $clog2(NUM_XC) : 1;

    typedef enum logic [1:0] {BANK_INT, BANK_FP, BANK_XC} bank_e;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

    typedef struct packed {
        bank_e      bank;
        logic [4:0] idx;
    } dec_t;

    // XC takes precedence over FP; anything not claimed by a present bank lands in the int bank.
    function automatic dec_t decode(input logic [6:0] addr, input logic fdis);
        dec_t d;
        d.bank = BANK_INT;
        d.idx  = addr[4:0];
        if (XPU != 0 && addr[6]) begin
            d.bank = BANK_XC;
            d.idx  = 5'(addr[XC_AW-1:0]);
        end else if (FPU != 0 && addr[5] && !fdis) begin
            d.bank = BANK_FP;
        end
        return d;
    endfunction

    state_e             state_q;
    logic [XC_AW-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               last_grp;

    logic [DATA_WIDTH-1:0] int_q [32];
    logic [DATA_WIDTH-1:0] fp_q  [32];
    logic [DATA_WIDTH-1:0] xc_q  [NUM_XC];

    dec_t wdec_a, wdec_b;
    logic wv_a, wv_b;

    assign wdec_a = decode(waddr_a_i, fregfile_disable_i);
    assign wdec_b = decode(waddr_b_i, fregfile_disable_i);

    // A write survives only if it targets a real register: never x0, never the XC bank mid-clear.
    assign wv_a = we_a_i && !(wdec_a.bank == BANK_INT && wdec_a.idx == 5'd0)
                         && !(wdec_a.bank == BANK_XC && busy_q);
    assign wv_b = we_b_i && !(wdec_b.bank == BANK_INT && wdec_b.idx == 5'd0)
                         && !(wdec_b.bank == BANK_XC && busy_q);

    assign last_grp = (int'(cnt_q) == NUM_XC - CLR_PER_CYCLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (xc_init_req_i && XPU != 0) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_q <= XC_AW'(int'(cnt_q) + CLR_PER_CYCLE);
                    if (last_grp) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the arrays are plain flops, not a RAM macro, so resetting every entry is legal and cheap
    // to express; a RAM-inferred array would have to drop the reset loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) int_q[i] <= '0;
        end else begin
            // NOTE: both are non-blocking updates to the same array; the later statement wins, which
            // is exactly how port B gets priority over port A on a shared target.
            if (wv_a && wdec_a.bank == BANK_INT) int_q[wdec_a.idx] <= wdata_a_i;
            if (wv_b && wdec_b.bank == BANK_INT) int_q[wdec_b.idx] <= wdata_b_i;
        end
    end

    if (FPU != 0) begin : g_fp
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < 32; i++) fp_q[i] <= '0;
            end else begin
                if (wv_a && wdec_a.bank == BANK_FP) fp_q[wdec_a.idx] <= wdata_a_i;
                if (wv_b && wdec_b.bank == BANK_FP) fp_q[wdec_b.idx] <= wdata_b_i;
            end
        end
    end else begin : g_no_fp
        assign fp_q = '{default: '0};
    end

    if (XPU != 0) begin : g_xc
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < NUM_XC; i++) xc_q[i] <= '0;
            end else begin
                if (wv_a && wdec_a.bank == BANK_XC) xc_q[wdec_a.idx[XC_AW-1:0]] <= wdata_a_i;
                if (wv_b && wdec_b.bank == BANK_XC) xc_q[wdec_b.idx[XC_AW-1:0]] <= wdata_b_i;
                if (state_q == CLEAR) begin
                    for (int j = 0; j < CLR_PER_CYCLE; j++) xc_q[XC_AW'(int'(cnt_q) + j)] <= '0;
                end
            end
        end
    end else begin : g_no_xc
        assign xc_q = '{default: '0};
    end

    logic [6:0]            raddr [3];
    logic [DATA_WIDTH-1:0] rdata [3];
    dec_t                  rdec  [3];

    assign raddr[0] = raddr_a_i;
    assign raddr[1] = raddr_b_i;
    assign raddr[2] = raddr_c_i;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdec[p] = decode(raddr[p], fregfile_disable_i);
            // NOTE: default first so every path assigns rdata and no latch is inferred.
            rdata[p] = '0;
            case (rdec[p].bank)
                BANK_INT: rdata[p] = int_q[rdec[p].idx];
                BANK_FP:  rdata[p] = fp_q[rdec[p].idx];
                BANK_XC:  if (!busy_q) rdata[p] = xc_q[rdec[p].idx[XC_AW-1:0]];
                default:  rdata[p] = '0;
            endcase
            if (WRITE_BYPASS != 0) begin
                if (wv_b && wdec_b == rdec[p])      rdata[p] = wdata_b_i;
                else if (wv_a && wdec_a == rdec[p]) rdata[p] = wdata_a_i;
            end
        end
    end

    assign rdata_a_o      = rdata[0];
    assign rdata_b_o      = rdata[1];
    assign rdata_c_o      = rdata[2];
    assign xc_init_busy_o = busy_q;
    assign xc_init_done_o = done_q;

endmodule

// File: tb/tb_riscv_banked_register_file.sv
// Bench for riscv_banked_register_file: two configurations driven in lockstep, checked every
// cycle against a bank-level model, plus literal expectations from hand-worked scenarios.
module tb_riscv_banked_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fdis;
    logic [6:0]  ra, rb, rc, wa, wb;
    logic [31:0] wda, wdb;
    logic        wea, web, req;

    logic [31:0] rda [2];
    logic [31:0] rdb [2];
    logic [31:0] rdc [2];
    logic        bsy [2];
    logic        dn  [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // dut0: FP bank, one XC register cleared per cycle, bypass on
    riscv_banked_register_file #(
        .DATA_WIDTH(32), .FPU(1), .XPU(1), .NUM_XC(16), .CLR_PER_CYCLE(1), .WRITE_BYPASS(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .fregfile_disable_i(fdis),
        .raddr_a_i(ra), .raddr_b_i(rb), .raddr_c_i(rc),
        .rdata_a_o(rda[0]), .rdata_b_o(rdb[0]), .rdata_c_o(rdc[0]),
        .waddr_a_i(wa), .waddr_b_i(wb), .wdata_a_i(wda), .wdata_b_i(wdb),
        .we_a_i(wea), .we_b_i(web), .xc_init_req_i(req),
        .xc_init_busy_o(bsy[0]), .xc_init_done_o(dn[0])
    );

    // dut1: no FP bank, four XC registers cleared per cycle, bypass off
    riscv_banked_register_file #(
        .DATA_WIDTH(32), .FPU(0), .XPU(1), .NUM_XC(16), .CLR_PER_CYCLE(4), .WRITE_BYPASS(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .fregfile_disable_i(fdis),
        .raddr_a_i(ra), .raddr_b_i(rb), .raddr_c_i(rc),
        .rdata_a_o(rda[1]), .rdata_b_o(rdb[1]), .rdata_c_o(rdc[1]),
        .waddr_a_i(wa), .waddr_b_i(wb), .wdata_a_i(wda), .wdata_b_i(wdb),
        .we_a_i(wea), .we_b_i(web), .xc_init_req_i(req),
        .xc_init_busy_o(bsy[1]), .xc_init_done_o(dn[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_int [2][32];
    logic [31:0] m_fp  [2][32];
    logic [31:0] m_xc  [2][16];
    int          m_left [2];   // CLEAR cycles still to run
    int          m_grp  [2];   // group number being cleared this cycle
    bit          m_done [2];

    function automatic bit cfg_fpu(input int c);  return c == 0; endfunction
    function automatic bit cfg_byp(input int c);  return c == 0; endfunction
    function automatic int cfg_cpc(input int c);  return (c == 0) ? 1 : 4; endfunction
    function automatic bit m_busy(input int c);   return m_left[c] > 0 || m_done[c]; endfunction

    function automatic void m_decode(input int c, input logic [6:0] a, output int bk, output int ix);
        if (a[6]) begin
            bk = 2; ix = int'(a[3:0]);
        end else if (a[5] && cfg_fpu(c) && !fdis) begin
            bk = 1; ix = int'(a[4:0]);
        end else begin
            bk = 0; ix = int'(a[4:0]);
        end
    endfunction

    function automatic bit m_wr_ok(input int c, input logic we, input logic [6:0] a);
        int bk, ix;
        m_decode(c, a, bk, ix);
        return we && !(bk == 0 && ix == 0) && !(bk == 2 && m_busy(c));
    endfunction

    function automatic logic [31:0] m_read(input int c, input logic [6:0] a);
        int bk, ix, bw, iw;
        m_decode(c, a, bk, ix);
        if (cfg_byp(c)) begin
            if (m_wr_ok(c, web, wb)) begin
                m_decode(c, wb, bw, iw);
                if (bw == bk && iw == ix) return wdb;
            end
            if (m_wr_ok(c, wea, wa)) begin
                m_decode(c, wa, bw, iw);
                if (bw == bk && iw == ix) return wda;
            end
        end
        case (bk)
            0:       return (ix == 0) ? 32'h0 : m_int[c][ix];
            1:       return m_fp[c][ix];
            default: return m_busy(c) ? 32'h0 : m_xc[c][ix];
        endcase
    endfunction

    function automatic void m_write(input int c, input logic [6:0] a, input logic [31:0] d);
        int bk, ix;
        m_decode(c, a, bk, ix);
        case (bk)
            0:       m_int[c][ix] = d;
            1:       m_fp[c][ix] = d;
            default: m_xc[c][ix] = d;
        endcase
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) begin m_int[c][i] = '0; m_fp[c][i] = '0; end
            for (int i = 0; i < 16; i++) m_xc[c][i] = '0;
            m_left[c] = 0; m_grp[c] = 0; m_done[c] = 1'b0;
        end
    endfunction

    function automatic void m_step();
        for (int c = 0; c < 2; c++) begin
            bit ok_a, ok_b;
            ok_a = m_wr_ok(c, wea, wa);
            ok_b = m_wr_ok(c, web, wb);
            if (ok_a) m_write(c, wa, wda);
            if (ok_b) m_write(c, wb, wdb);
            if (m_left[c] > 0) begin
                for (int j = 0; j < cfg_cpc(c); j++) m_xc[c][m_grp[c] * cfg_cpc(c) + j] = '0;
                m_grp[c]++;
                m_left[c]--;
                if (m_left[c] == 0) m_done[c] = 1'b1;
            end else if (m_done[c]) begin
                m_done[c] = 1'b0;
            end else if (req) begin
                m_left[c] = 16 / cfg_cpc(c);
                m_grp[c]  = 0;
            end
        end
    endfunction

    // Inputs only change just after posedge, so the negedge sees them settled.
    always @(negedge clk) begin
        if (!rst_n) m_reset();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("dut%0d busy", c), {31'b0, bsy[c]}, {31'b0, m_busy(c)});
            check($sformatf("dut%0d done", c), {31'b0, dn[c]},  {31'b0, m_done[c]});
            check($sformatf("dut%0d rdata_a @%h", c, ra), rda[c], m_read(c, ra));
            check($sformatf("dut%0d rdata_b @%h", c, rb), rdb[c], m_read(c, rb));
            check($sformatf("dut%0d rdata_c @%h", c, rc), rdc[c], m_read(c, rc));
        end
        if (rst_n) m_step();
    end

    // ---------------- stimulus ----------------
    task automatic half(); @(negedge clk); #1; endtask
    task automatic full(); @(posedge clk); #1; endtask

    task automatic idle_ctl();
        wea = 1'b0; web = 1'b0; req = 1'b0;
    endtask

    function automatic logic [6:0] taddr(input int i);
        return 7'(i < 32 ? i : i + 32);
    endfunction

    // Runs up to 30 cycles after a request and reports busy length and done position per DUT.
    task automatic run_clear(input bit hooks, output int b0, output int b1,
                             output int d0, output int d1, output int dc0, output int dc1);
        b0 = 0; b1 = 0; d0 = 0; d1 = 0; dc0 = 0; dc1 = 0;
        for (int k = 1; k <= 30; k++) begin
            if (hooks) begin
                case (k)
                    3: begin
                        wea = 1'b1; wa = 7'h43; wda = 32'h0000_1234;
                        web = 1'b1; wb = 7'h07; wdb = 32'h0000_5678;
                    end
                    4: begin wea = 1'b0; web = 1'b0; end
                    5: req = 1'b1;
                    6: req = 1'b0;
                    default: ;
                endcase
            end
            half();
            if (hooks && k == 1) check("t4 xc3 read while busy", rdc[0], 32'h0);
            if (bsy[0]) b0++;
            if (bsy[1]) b1++;
            if (dn[0]) begin dc0++; d0 = k; end
            if (dn[1]) begin dc1++; d1 = k; end
            full();
        end
    endtask

    initial begin
        int b0, b1, d0, d1, dc0, dc1;
        rst_n = 1'b0; fdis = 1'b0;
        ra = '0; rb = '0; rc = '0; wa = '0; wb = '0; wda = '0; wdb = '0;
        idle_ctl();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: everything reads zero after reset; x0 ignores writes
        for (int i = 0; i < 48; i += 3) begin
            ra = taddr(i); rb = taddr(i + 1); rc = taddr(i + 2);
            full();
        end
        wea = 1'b1; wa = 7'h00; wda = 32'hDEAD_BEEF; ra = 7'h00;
        half();
        check("t1 x0 same-cycle dut0", rda[0], 32'h0);
        full();
        idle_ctl();
        half();
        check("t1 x0 after write dut0", rda[0], 32'h0);
        check("t1 x0 after write dut1", rda[1], 32'h0);
        full();

        // 2: B beats A on x5; bypass on dut0 only
        wea = 1'b1; wa = 7'h05; wda = 32'h1111_1111;
        web = 1'b1; wb = 7'h05; wdb = 32'h2222_2222;
        ra = 7'h05;
        half();
        check("t2 x5 bypass dut0", rda[0], 32'h2222_2222);
        check("t2 x5 old value dut1", rda[1], 32'h0);
        full();
        idle_ctl();
        wea = 1'b1; wa = 7'h06; wda = 32'h0000_600D; rb = 7'h06;
        half();
        check("t2 x5 next cycle dut0", rda[0], 32'h2222_2222);
        check("t2 x5 next cycle dut1", rda[1], 32'h2222_2222);
        check("t2 x6 A bypass dut0", rdb[0], 32'h0000_600D);
        check("t2 x6 no bypass dut1", rdb[1], 32'h0);
        full();
        idle_ctl();

        // 5: 0x25 is f5 on dut0, aliases to x5 on dut1
        wea = 1'b1; wa = 7'h25; wda = 32'h0000_CAFE;
        full();
        idle_ctl(); ra = 7'h25;
        half();
        check("t5 f5 dut0", rda[0], 32'h0000_CAFE);
        check("t5 x5 alias dut1", rda[1], 32'h0000_CAFE);
        full();
        fdis = 1'b1;
        half();
        check("t5 disabled -> x5 dut0", rda[0], 32'h2222_2222);
        check("t5 disabled -> x5 dut1", rda[1], 32'h0000_CAFE);
        full();
        fdis = 1'b0;

        // 3: preload XC bank, then clear it
        for (int i = 0; i < 16; i += 2) begin
            wea = 1'b1; wa = 7'(64 + i);     wda = 32'hA5A5_A5A0 + 32'(i);
            web = 1'b1; wb = 7'(64 + i + 1); wdb = 32'hA5A5_A5A0 + 32'(i + 1);
            ra = 7'(64 + i); rb = 7'h41;
            full();
        end
        idle_ctl(); ra = 7'h4F;
        half();
        check("t3 xc15 preload dut0", rda[0], 32'hA5A5_A5AF);
        check("t3 xc15 preload dut1", rda[1], 32'hA5A5_A5AF);
        full();
        req = 1'b1; rc = 7'h43;
        full();
        req = 1'b0;

        // 4: writes and a second request during the clear
        run_clear(1'b1, b0, b1, d0, d1, dc0, dc1);
        idle_ctl();
        check("t3 dut0 busy cycles", b0, 17);
        check("t3 dut0 done cycle", d0, 17);
        check("t3 dut0 done pulses", dc0, 1);
        check("t3 dut1 busy cycles", b1, 5);
        check("t3 dut1 done cycle", d1, 5);
        check("t3 dut1 done pulses", dc1, 1);
        ra = 7'h43; rb = 7'h07;
        half();
        check("t4 xc3 after clear dut0", rda[0], 32'h0);
        check("t4 xc3 after clear dut1", rda[1], 32'h0);
        check("t4 x7 kept dut0", rdb[0], 32'h0000_5678);
        check("t4 x7 kept dut1", rdb[1], 32'h0000_5678);
        full();
        for (int i = 0; i < 16; i += 2) begin
            ra = 7'(64 + i); rb = 7'(64 + i + 1);
            full();
        end

        // 6: reset in the middle of a clear
        wea = 1'b1; wa = 7'h41; wda = 32'h0000_0077;
        web = 1'b1; wb = 7'h09; wdb = 32'h0000_0099;
        full();
        idle_ctl(); req = 1'b1;
        full();
        req = 1'b0;
        repeat (3) full();
        rst_n = 1'b0;
        half();
        check("t6 busy drops dut0", {31'b0, bsy[0]}, 32'h0);
        check("t6 busy drops dut1", {31'b0, bsy[1]}, 32'h0);
        check("t6 no done dut1", {31'b0, dn[1]}, 32'h0);
        full();
        ra = 7'h09; rb = 7'h41; rc = 7'h25;
        half();
        check("t6 x9 cleared dut0", rda[0], 32'h0);
        check("t6 xc1 cleared dut1", rdb[1], 32'h0);
        check("t6 f5 cleared dut0", rdc[0], 32'h0);
        full();
        rst_n = 1'b1;
        req = 1'b1;
        full();
        req = 1'b0;
        run_clear(1'b0, b0, b1, d0, d1, dc0, dc1);
        check("t6 dut1 busy cycles", b1, 5);
        check("t6 dut1 done cycle", d1, 5);
        check("t6 dut0 busy cycles", b0, 17);
        check("t6 dut0 done pulses", dc0, 1);

        full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
